mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of four requesters exclusive use of a
// shared memory port, with per-transaction completion and timeout pulses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_read,
  input  logic [3:0] req_write,
  input  logic       mem_resp,
  output logic [1:0] sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       busy,
  output logic [3:0] resp,
  output logic [3:0] err
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pending;
  logic             found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic             in_busy;
  logic             timeout_hit;

  // Rotating priority search starting at ptr.
  always_comb begin
    pending   = req_read | req_write;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q + IDX_W'(k);
      if (!found && pending[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign in_busy     = (state_q == BUSY);
  // A response in the final cycle beats the timeout.
  assign timeout_hit = in_busy && (cnt_q == CNT_LAST) && !mem_resp;

  // Next-state logic: grant from IDLE, complete or time out from BUSY.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = grant_idx;
          op_d    = req_write[grant_idx] ? OP_WRITE : OP_READ;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp || timeout_hit) begin
          state_d = IDLE;
          ptr_d   = owner_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = owner_q;
  assign busy      = in_busy;
  assign mem_read  = in_busy && (op_q == OP_READ);
  assign mem_write = in_busy && (op_q == OP_WRITE);
  assign resp      = (in_busy && mem_resp) ? (N_REQ'(1) << owner_q) : '0;
  assign err       = timeout_hit ? (N_REQ'(1) << owner_q) : '0;

endmodule
